// File: rtl/traffic_light_ctrl_nway.sv
// ============================================================================
// traffic_light_ctrl_nway
// Round-robin N-approach signal controller with pedestrian walk and night flash.
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_light_ctrl_nway #(
    parameter int NUM_DIR  = 2,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 6,
    parameter int FLASH_T  = 2,
    localparam int DIR_W   = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DIR-1:0]     car_req,
    input  logic                   ped_req,
    input  logic                   night_mode,
    output logic [3*NUM_DIR-1:0]   lights,
    output logic                   walk,
    output logic [DIR_W-1:0]       active_dir,
    output logic [2:0]             state
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WALK   = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DIR_W-1:0]     r_dir;
    logic [DIR_W-1:0]     w_next_dir;
    logic [DIR_W-1:0]     w_rr_dir;
    logic [CNT_W-1:0]     r_timer;
    logic [CNT_W-1:0]     w_load_val;
    logic [PRESC_W-1:0]   r_presc;
    logic [NUM_DIR-1:0]   w_rot;
    logic                 r_ped;
    logic                 r_flash_on;
    logic                 w_tick;
    logic                 w_expire;

    assign w_tick   = (r_presc == PRESC_MAX);
    assign w_expire = w_tick && (r_timer == '0);

    // Bit m of w_rot is approach (r_dir+1+m) mod NUM_DIR; the lowest set bit wins.
    assign w_rot = NUM_DIR'({car_req, car_req} >> (r_dir + DIR_W'(1)));

    always_comb begin
        w_rr_dir = DIR_W'((int'(r_dir) + 1) % NUM_DIR);
        for (int m = NUM_DIR - 1; m >= 0; m--) begin
            if (w_rot[m]) begin
                w_rr_dir = DIR_W'((int'(r_dir) + 1 + m) % NUM_DIR);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_dir;
        w_load_val   = ALLRED_LD;
        if (w_expire) begin
            case (r_state)
                ST_ALLRED: begin
                    if (night_mode) begin
                        w_next_state = ST_FLASH;
                    end else if (r_ped) begin
                        w_next_state = ST_WALK;
                    end else begin
                        w_next_state = ST_GREEN;
                        w_next_dir   = w_rr_dir;
                    end
                end
                ST_GREEN:  w_next_state = ST_YELLOW;
                ST_YELLOW: w_next_state = ST_ALLRED;
                ST_WALK:   w_next_state = ST_ALLRED;
                // Leave flash mode only after a dark half-period
                ST_FLASH: begin
                    if (!r_flash_on && !night_mode) begin
                        w_next_state = ST_ALLRED;
                    end
                end
                default:   w_next_state = ST_ALLRED;
            endcase
        end
        case (w_next_state)
            ST_GREEN:  w_load_val = GREEN_LD;
            ST_YELLOW: w_load_val = YELLOW_LD;
            ST_WALK:   w_load_val = WALK_LD;
            ST_FLASH:  w_load_val = FLASH_LD;
            default:   w_load_val = ALLRED_LD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_ALLRED;
            r_dir      <= DIR_W'(NUM_DIR - 1);
            r_timer    <= ALLRED_LD;
            r_presc    <= '0;
            r_ped      <= 1'b0;
            r_flash_on <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dir   <= w_next_dir;
            // Transitions only happen on a tick, so the wrap also restarts each state
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_expire) begin
                r_timer <= w_load_val;
            end else if (w_tick) begin
                r_timer <= r_timer - CNT_W'(1);
            end
            if (w_expire) begin
                if (w_next_state == ST_FLASH) begin
                    r_flash_on <= (r_state == ST_FLASH) ? ~r_flash_on : 1'b1;
                end else begin
                    r_flash_on <= 1'b0;
                end
            end
            if (w_expire && (w_next_state == ST_WALK)) begin
                r_ped <= 1'b0;
            end else if (ped_req && (r_state != ST_WALK)) begin
                r_ped <= 1'b1;
            end
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            case (r_state)
                ST_GREEN:  lights[3*i +: 3] = (DIR_W'(i) == r_dir) ? 3'b001 : 3'b100;
                ST_YELLOW: lights[3*i +: 3] = (DIR_W'(i) == r_dir) ? 3'b010 : 3'b100;
                ST_FLASH:  lights[3*i +: 3] = r_flash_on ? 3'b010 : 3'b000;
                default:   lights[3*i +: 3] = 3'b100;
            endcase
        end
    end

    assign walk       = (r_state == ST_WALK);
    assign active_dir = r_dir;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl_nway.sv
// ============================================================================
// tb_traffic_light_ctrl_nway
// Directed phase sequences plus random traffic against a clock-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl_nway;

    localparam int N  = 3;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int WT = 4;
    localparam int FT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] car_req = 3'b000;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [8:0] lights;
    logic       walk;
    logic [1:0] active_dir;
    logic [2:0] state;

    logic       rst3 = 1'b0;
    logic [2:0] car_req3 = 3'b000;
    logic       ped_req3 = 1'b0;
    logic       night3 = 1'b0;
    logic [8:0] lights3;
    logic       walk3;
    logic [1:0] active_dir3;
    logic [2:0] state3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl_nway #(
        .NUM_DIR(N), .CNT_W(8), .TICK_DIV(1), .GREEN_T(GT), .YELLOW_T(YT),
        .ALLRED_T(AT), .WALK_T(WT), .FLASH_T(FT)
    ) u_dut (
        .clk(clk), .rst(rst), .car_req(car_req), .ped_req(ped_req),
        .night_mode(night_mode), .lights(lights), .walk(walk),
        .active_dir(active_dir), .state(state)
    );

    traffic_light_ctrl_nway #(
        .NUM_DIR(N), .CNT_W(8), .TICK_DIV(3), .GREEN_T(GT), .YELLOW_T(YT),
        .ALLRED_T(AT), .WALK_T(WT), .FLASH_T(FT)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .car_req(car_req3), .ped_req(ped_req3),
        .night_mode(night3), .lights(lights3), .walk(walk3),
        .active_dir(active_dir3), .state(state3)
    );

    // Lamp pattern implied by a phase (0 AR,1 G,2 Y,3 WALK,4 FLASH) and served approach
    function automatic logic [8:0] lamps(int st, int dr, bit fl);
        logic [8:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (st == 1)      v[3*i +: 3] = (i == dr) ? 3'b001 : 3'b100;
            else if (st == 2) v[3*i +: 3] = (i == dr) ? 3'b010 : 3'b100;
            else if (st == 4) v[3*i +: 3] = fl ? 3'b010 : 3'b000;
            else              v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    function automatic logic [14:0] expv(int st, int dr, bit fl);
        return {st[2:0], lamps(st, dr, fl), (st == 3), dr[1:0]};
    endfunction

    // Reference model: phase plus clocks remaining in it
    int m_state = 0;
    int m_dir   = N - 1;
    int m_left  = AT;
    bit m_ped   = 1'b0;
    bit m_flash = 1'b0;

    always @(posedge clk) begin : p_model
        int st, dr, lf;
        bit pd, fl, found;
        st = m_state; dr = m_dir; lf = m_left - 1; pd = m_ped; fl = m_flash;
        if (lf == 0) begin
            case (m_state)
                0: begin
                    if (night_mode) begin
                        st = 4; lf = FT; fl = 1'b1;
                    end else if (m_ped) begin
                        st = 3; lf = WT;
                    end else begin
                        st = 1; lf = GT; dr = (m_dir + 1) % N; found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            if (!found && car_req[(m_dir + k) % N]) begin
                                dr = (m_dir + k) % N; found = 1'b1;
                            end
                        end
                    end
                end
                1: begin st = 2; lf = YT; end
                2: begin st = 0; lf = AT; end
                3: begin st = 0; lf = AT; end
                default: begin
                    if (!m_flash && !night_mode) begin
                        st = 0; lf = AT; fl = 1'b0;
                    end else begin
                        fl = !m_flash; lf = FT;
                    end
                end
            endcase
        end
        if (st == 3 && m_state != 3) pd = 1'b0;
        else if (ped_req && m_state != 3) pd = 1'b1;
        if (!rst) begin
            st = 0; dr = N - 1; lf = AT; pd = 1'b0; fl = 1'b0;
        end
        m_state <= st; m_dir <= dr; m_left <= lf; m_ped <= pd; m_flash <= fl;
    end

    task automatic do_reset(input logic [2:0] car);
        @(negedge clk);
        rst = 1'b0; car_req = car; ped_req = 1'b0; night_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(3'b000);
        n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
        n_vec++; if (lights !== 9'b100100100) begin n_bad++; $display("FAIL reset_lights got %b exp 100100100", lights); end
        n_vec++; if (walk !== 1'b0) begin n_bad++; $display("FAIL reset_walk got %b exp 0", walk); end
        n_vec++; if (active_dir !== 2'd2) begin n_bad++; $display("FAIL reset_dir got %0d exp 2", active_dir); end
    endtask

    // Continues straight from test_reset with no cars waiting
    task automatic test_rotation();
        for (int c = 0; c < 10; c++) begin
            int p, st;
            @(negedge clk);
            p  = c % 8;
            st = (p < 5) ? 1 : (p < 7) ? 2 : 0;
            n_vec++;
            if ({state, lights, walk, active_dir} !== expv(st, (c < 8) ? 0 : 1, 1'b0)) begin
                n_bad++;
                $display("FAIL rotation c=%0d got %h exp %h", c, {state, lights, walk, active_dir}, expv(st, (c < 8) ? 0 : 1, 1'b0));
            end
        end
    endtask

    task automatic test_skip();
        do_reset(3'b001);
        for (int c = 0; c <= 16; c++) begin
            int p, st;
            @(negedge clk);
            p  = c % 8;
            st = (p < 5) ? 1 : (p < 7) ? 2 : 0;
            n_vec++;
            if ({state, lights, walk, active_dir} !== expv(st, (c < 16) ? 0 : 2, 1'b0)) begin
                n_bad++;
                $display("FAIL skip c=%0d got %h exp %h", c, {state, lights, walk, active_dir}, expv(st, (c < 16) ? 0 : 2, 1'b0));
            end
            if (c == 10) car_req = 3'b100;
        end
        n_vec++; if (lights !== 9'b001100100) begin n_bad++; $display("FAIL skip_dir2_lights got %b exp 001100100", lights); end
    endtask

    task automatic test_pedestrian();
        do_reset(3'b000);
        for (int c = 0; c <= 21; c++) begin
            int st, dr;
            @(negedge clk);
            st = (c < 5) ? 1 : (c < 7) ? 2 : (c == 7) ? 0 : (c < 12) ? 3 : (c == 12) ? 0 :
                 (c < 18) ? 1 : (c < 20) ? 2 : (c == 20) ? 0 : 1;
            dr = (c <= 12) ? 0 : (c <= 20) ? 1 : 2;
            n_vec++;
            if ({state, lights, walk, active_dir} !== expv(st, dr, 1'b0)) begin
                n_bad++;
                $display("FAIL pedestrian c=%0d got %h exp %h", c, {state, lights, walk, active_dir}, expv(st, dr, 1'b0));
            end
            ped_req = (c == 1) || (c == 9);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_night();
        do_reset(3'b000);
        for (int c = 0; c <= 17; c++) begin
            int st;
            bit fl;
            @(negedge clk);
            st = (c < 5) ? 1 : (c < 7) ? 2 : (c == 7) ? 0 : (c < 16) ? 4 : (c == 16) ? 0 : 1;
            fl = (c == 8) || (c == 9) || (c == 12) || (c == 13);
            n_vec++;
            if ({state, lights, walk, active_dir} !== expv(st, (c < 17) ? 0 : 1, fl)) begin
                n_bad++;
                $display("FAIL night c=%0d got %h exp %h", c, {state, lights, walk, active_dir}, expv(st, (c < 17) ? 0 : 1, fl));
            end
            if (c == 1) night_mode = 1'b1;
            if (c == 12) night_mode = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        do_reset(3'b000);
        repeat (6) @(negedge clk);
        n_vec++; if (state !== 3'd2) begin n_bad++; $display("FAIL midreset_pre got %0d exp 2", state); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_vec++;
        if ({state, lights, walk, active_dir} !== {3'd0, 9'b100100100, 1'b0, 2'd2}) begin
            n_bad++;
            $display("FAIL midreset got %h exp %h", {state, lights, walk, active_dir}, {3'd0, 9'b100100100, 1'b0, 2'd2});
        end
    endtask

    // ALLRED after reset spans 3 clocks: the reset cycle plus two more
    task automatic test_prescaler();
        int cnt[5];
        cnt = '{default: 0};
        @(negedge clk);
        rst3 = 1'b1;
        for (int c = 0; c <= 23; c++) begin
            @(negedge clk);
            if (c < 23 && state3 <= 3'd4) cnt[state3]++;
            if (c == 23) begin
                n_vec++; if (state3 !== 3'd0) begin n_bad++; $display("FAIL presc_end got %0d exp 0", state3); end
            end
        end
        n_vec++; if (cnt[0] != 2) begin n_bad++; $display("FAIL presc_allred got %0d exp 2", cnt[0]); end
        n_vec++; if (cnt[1] != 15) begin n_bad++; $display("FAIL presc_green got %0d exp 15", cnt[1]); end
        n_vec++; if (cnt[2] != 6) begin n_bad++; $display("FAIL presc_yellow got %0d exp 6", cnt[2]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_vec++;
            if ({state, lights, walk, active_dir} !== expv(m_state, m_dir, m_flash)) begin
                n_bad++;
                $display("FAIL random c=%0d got %h exp %h", c, {state, lights, walk, active_dir}, expv(m_state, m_dir, m_flash));
            end
            car_req = ($urandom_range(3) == 0) ? 3'b000 : 3'($urandom);
            ped_req = ($urandom_range(24) == 0);
            if ($urandom_range(119) == 0) night_mode = !night_mode;
            rst = !($urandom_range(399) == 0);
        end
        rst = 1'b1; night_mode = 1'b0; ped_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_skip();
        test_pedestrian();
        test_night();
        test_mid_reset();
        test_prescaler();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
